// File: rtl/cic3_decim.sv
// Third-order CIC (sinc3) decimator: 1-bit delta-sigma stream in, unsigned PCM samples out.
// Optional CIC_WARMUP_MASK_EN suppresses the first two transient samples after reset/clr.
module cic3_decim #(
  parameter int unsigned LOG2_DECIM = 6,
  parameter int unsigned OUT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 bit_in,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 out_valid
);

  localparam int unsigned W   = 3 * LOG2_DECIM + 1;
  localparam int unsigned FS  = 3 * LOG2_DECIM;
  localparam int unsigned LSB = FS - OUT_WIDTH;

  logic [W-1:0]          i1, i2, i3;
  logic [W-1:0]          d1, d2, d3;
  logic [W-1:0]          i1_next, i2_next, i3_next;
  logic [W-1:0]          c1, c2, c3;
  logic [LOG2_DECIM-1:0] cnt;
  logic                  strobe;
  logic                  emit;
  logic [OUT_WIDTH-1:0]  out_next;

`ifdef CIC_WARMUP_MASK_EN
  logic [1:0] warm;
`endif

  // Cascaded integrators, comb and output scaling; all filter arithmetic wraps modulo 2^W
  always_comb begin
    i1_next  = i1 + W'(bit_in);
    i2_next  = i2 + i1_next;
    i3_next  = i3 + i2_next;
    strobe   = en && (cnt == '1);
    c1       = i3_next - d1;
    c2       = c1 - d2;
    c3       = c2 - d3;
    out_next = c3[W-1] ? '1 : OUT_WIDTH'(c3 >> LSB);
`ifdef CIC_WARMUP_MASK_EN
    emit     = strobe && warm[1];
`else
    emit     = strobe;
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      i1        <= '0;
      i2        <= '0;
      i3        <= '0;
      d1        <= '0;
      d2        <= '0;
      d3        <= '0;
      cnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else if (clr) begin
      i1        <= '0;
      i2        <= '0;
      i3        <= '0;
      d1        <= '0;
      d2        <= '0;
      d3        <= '0;
      cnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= emit;
      if (en) begin
        i1  <= i1_next;
        i2  <= i2_next;
        i3  <= i3_next;
        cnt <= cnt + LOG2_DECIM'(1);
      end
      if (strobe) begin
        d1 <= i3_next;
        d2 <= c1;
        d3 <= c2;
      end
      if (emit) begin
        out <= out_next;
      end
    end
  end

`ifdef CIC_WARMUP_MASK_EN
  // Saturating count of strobes since reset/clr; samples are released from the third on
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      warm <= 2'd0;
    end else if (clr) begin
      warm <= 2'd0;
    end else if (strobe && (warm != 2'd3)) begin
      warm <= warm + 2'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cic3_decim.sv
// Bench for cic3_decim: directed and random bit streams checked against a sinc3
// convolution model (impulse response = three cascaded length-R boxcars).
module tb_cic3_decim;

  localparam int unsigned L  = 6;
  localparam int unsigned OW = 16;
  localparam int unsigned R  = 1 << L;
  localparam int unsigned HL = 3 * R - 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic          en;
  logic          clr;
  logic          bit_in;
  logic [OW-1:0] out;
  logic          out_valid;

  int checks   = 0;
  int failures = 0;

  bit      hist[$];
  longint  h[HL];
  int      strobes;
  logic [OW-1:0] exp_out;
  logic          exp_valid;
  int      cyc;
  int      last_v;
  int      period_exp;

  cic3_decim #(.LOG2_DECIM(L), .OUT_WIDTH(OW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .clr       (clr),
    .bit_in    (bit_in),
    .out       (out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Exact sinc3 output for the bits accepted since the last reset/clr
  function automatic logic [OW-1:0] ref_sample();
    longint y = 0;
    int n = hist.size();
    for (int j = 0; j < int'(HL) && j < n; j++) begin
      if (hist[n-1-j]) y += h[j];
    end
    if (y >= (longint'(1) << (3 * L))) return '1;
    return OW'(y >> (3 * L - OW));
  endfunction

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, expv, cyc);
    end
  endtask

  task automatic model_clear();
    hist.delete();
    strobes   = 0;
    exp_out   = '0;
    exp_valid = 1'b0;
  endtask

  task automatic step(input logic e, input logic b, input logic c);
    en = e; bit_in = b; clr = c;
    @(posedge clk);
    #1;
    cyc++;
    exp_valid = 1'b0;
    if (c) begin
      model_clear();
    end else if (e) begin
      hist.push_back(b);
      if ((hist.size() % R) == 0) begin
        strobes++;
`ifdef CIC_WARMUP_MASK_EN
        if (strobes >= 3) begin
          exp_valid = 1'b1;
          exp_out   = ref_sample();
        end
`else
        exp_valid = 1'b1;
        exp_out   = ref_sample();
`endif
      end
    end
    check("out_valid", OW'(out_valid), OW'(exp_valid));
    check("out", out, exp_out);
    if (out_valid === 1'b1 && period_exp != 0) begin
      if (last_v >= 0) check("valid_period", OW'(cyc - last_v), OW'(period_exp));
      last_v = cyc;
    end
  endtask

  initial begin
    longint b2[2*R-1];
    for (int i = 0; i < int'(2*R-1); i++) begin
      b2[i] = longint'(((i < int'(2*R-2-i)) ? i : int'(2*R-2-i)) + 1);
    end
    for (int k = 0; k < int'(HL); k++) begin
      h[k] = 0;
      for (int i = k - int'(R) + 1; i <= k; i++) begin
        if (i >= 0 && i < int'(2*R-1)) h[k] += b2[i];
      end
    end

    cyc = 0; last_v = -1; period_exp = 0;
    model_clear();
    rstn = 1'b0; en = 1'b0; clr = 1'b0; bit_in = 1'b0;
    #2;
    check("reset_out", out, '0);
    check("reset_valid", OW'(out_valid), '0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Constant ones: saturated full scale, one sample every R clocks
    period_exp = R; last_v = -1;
    for (int i = 0; i < int'(5*R); i++) step(1'b1, 1'b1, 1'b0);
    check("ones_fullscale", out, 16'hFFFF);

    // Clear with en=1 discards the bit and zeroes the output
    period_exp = 0;
    step(1'b1, 1'b1, 1'b1);
    check("clr_out", out, '0);

    // Constant zeros
    for (int i = 0; i < int'(4*R); i++) step(1'b1, 1'b0, 1'b0);
    check("zeros_out", out, 16'h0000);

    // Alternating 1,0: half scale
    step(1'b0, 1'b0, 1'b1);
    period_exp = R; last_v = -1;
    for (int i = 0; i < int'(5*R); i++) step(1'b1, (i % 2) == 0, 1'b0);
    check("alt_half", out, 16'h8000);

    // Same stream with en toggling every clock: period doubles, out holds while en=0
    step(1'b0, 1'b0, 1'b1);
    period_exp = 2 * R; last_v = -1;
    for (int i = 0; i < int'(10*R); i++) step((i % 2) == 0, ((i / 2) % 2) == 0, 1'b0);
    check("alt_gated_half", out, 16'h8000);

    // clr 20 bits into an all-ones frame, then resume
    period_exp = 0;
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < int'(3*R + 4); i++) step(1'b1, 1'b1, 1'b0);

    // Async reset 20 bits into a frame, then resume
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    model_clear();
    check("midreset_out", out, '0);
    check("midreset_valid", OW'(out_valid), '0);
    @(posedge clk);
    #1;
    check("held_reset_valid", OW'(out_valid), '0);
    rstn = 1'b1;
    for (int i = 0; i < int'(3*R + 4); i++) step(1'b1, 1'b1, 1'b0);

    // Random sparse stream (density ~0.25) with random enable gaps
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < int'(12*R); i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cic3_decim.md
Name: cic3_decim

Overview:
- Third-order CIC (sinc3) decimator that turns the 1-bit delta-sigma stream back into multi-bit PCM samples; it is the demodulator counterpart to the 2nd-order modulator.
- Consumes one bit per enabled clock and emits one unsigned OUT_WIDTH-bit sample every 2^LOG2_DECIM enabled bits, with a one-cycle valid strobe.
- Used in loopback test benches and on the receive side of the QNS datapath.

Parameters:
LOG2_DECIM, 6, log2 of decimation ratio R (R = 64 by default); range 2..8
OUT_WIDTH, 16, output word width, unsigned fraction with OUT_WIDTH fractional bits (1.0 = 2^OUT_WIDTH); constraint 3*LOG2_DECIM >= OUT_WIDTH

Ports:
clk  input  1  clock
rstn  input  1  reset, asynchronous, active-low
en  input  1  bit-rate enable; bit_in sampled only when en=1
clr  input  1  synchronous clear of all filter state, counter and warm-up state; has priority over en
bit_in  input  1  modulator output bit; 1 = +full-scale, 0 = zero
out  output  OUT_WIDTH  decimated sample, held between strobes
out_valid  output  1  one-cycle pulse when out updates

Behaviour:
- Internal width W = 3*LOG2_DECIM + 1 (19 by default). All integrator and comb arithmetic is modulo 2^W, and wrap-around is intentional. Do not saturate inside the filter.
- Reset (rstn=0, async) and clr=1 (sync) have the same effect:
  - integrators, comb delay registers and the decimation counter go to 0;
  - out goes to 0 and out_valid goes to 0;
  - the warm-up counter goes to 0.
- Integrator section, updated only on clock edges where en=1:
  - i1 <= i1 + bit_in (zero-extended to W bits);
  - i2 <= i2 + i1_next;
  - i3 <= i3 + i2_next;
  - i1_next and i2_next are the new values formed in the same cycle (cascaded combinationally), so i3 reflects the current bit.
- Decimation counter:
  - LOG2_DECIM bits, increments on each en=1 cycle and wraps from R-1 to 0.
  - The decimation strobe is asserted when the counter equals R-1 and en=1.
- Comb section, updated only on the strobe, differential delay M=1, computed combinationally from i3_next:
  - c1 = i3_next - d1, c2 = c1 - d2, c3 = c2 - d3;
  - d1 <= i3_next, d2 <= c1, d3 <= c2.
- Output scaling and saturation:
  - steady-state full scale is c3 = R^3 = 2^(3*LOG2_DECIM);
  - if c3 >= 2^(3*LOG2_DECIM), out <= all ones (saturate);
  - otherwise out <= c3[3*LOG2_DECIM-1 : 3*LOG2_DECIM-OUT_WIDTH] (truncate, no rounding).
- Timing:
  - out and out_valid are registered; out_valid=1 in the cycle immediately after the strobe edge and 0 otherwise;
  - latency from the R-th enabled bit of a frame to out_valid is 1 clock.
- en=0: all state, including the counter, holds. out holds. out_valid is 0 in any cycle not directly following a strobe.
- clr together with en=1: clr wins; that bit is discarded and no strobe occurs.
- Warm-up: the first 2 samples after reset or clr are filter transients; the 3rd and later samples are valid. Without the optional feature they are still flagged valid.
- A reset asserted mid-frame aborts the frame and the partial accumulation is lost. After release, the first strobe comes R enabled bits later.

Optional Feature:
- Macro: CIC_WARMUP_MASK_EN.
- When defined:
  - a 2-bit saturating warm-up counter increments on each strobe;
  - out_valid is suppressed, and out is not updated, for the first 2 strobes after reset or clr;
  - the first out_valid follows the 3rd strobe (3*R enabled bits).
- When undefined: every strobe produces out_valid, including the transients.

Test Plan:
- bit_in=1 constant, en=1 constant, R=64 -> samples 3 onward: out=16'hFFFF (saturated from c3=2^18); out_valid period exactly 64 clocks.
- bit_in=0 constant -> every out=16'h0000.
- bit_in alternating 1,0 -> from sample 3: out=16'h8000 (c3=2^17).
- Same alternating stream with en toggling 1,0 every clock -> identical out values; out_valid period 128 clocks; out stable while en=0.
- Drive rstn low, or clr high, 20 bits into a frame of all-ones, then resume -> out=0 and out_valid=0 during reset. The first strobe comes 64 enabled bits after release. With CIC_WARMUP_MASK_EN, the first out_valid comes 192 enabled bits after release.
- Loopback with mod2 (in=16'h4000, mod2 en tied to this block's en) -> the modulator's bit density is 0.25, so steady-state out is 16'h4000 ± 4 LSB over 100 samples.
